// File: rtl/hazard_ctl_if.sv
// Pipeline-to-hazard-controller bundle: registered IF/ID and ID/EX fields go in,
// and the stall, bubble and flush controls plus the debug state and stall counter come back.
interface hazard_ctl_if #(
   parameter int CNT_W = 16
) ();
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             ifid_uses_rt;
   logic [2:0]       idex_m_ctl;
   logic [4:0]       idex_rt;
   logic             exmem_branch_taken;
   logic             pc_write;
   logic             ifid_write;
   logic             idex_bubble;
   logic             ifid_flush;
   logic [1:0]       hazard_state;
   logic [CNT_W-1:0] stall_count;

   // No valid/ready handshake: every field is sampled each cycle.
   // The controls returned by the controller apply to the edge that closes the current cycle.
   modport master (
      output ifid_rs, ifid_rt, ifid_uses_rt, idex_m_ctl, idex_rt, exmem_branch_taken,
      input  pc_write, ifid_write, idex_bubble, ifid_flush, hazard_state, stall_count
   );

   modport slave (
      input  ifid_rs, ifid_rt, ifid_uses_rt, idex_m_ctl, idex_rt, exmem_branch_taken,
      output pc_write, ifid_write, idex_bubble, ifid_flush, hazard_state, stall_count
   );
endinterface

// File: rtl/hazard_ctl.sv
// Hazard controller: handles load-use stalls with optional extra memory-wait cycles and taken-branch flushes.
// It also keeps a saturating counter of stalled cycles.
module hazard_ctl #(
   parameter int MEMREAD_BIT = 1,
   parameter int MEM_WAIT    = 0,
   parameter int CNT_W       = 16
) (
   input logic          clk,
   input logic          rst,
   hazard_ctl_if.slave  bus
);
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1
   } state_t;

   localparam logic [3:0]       WAIT_INIT = 4'(MEM_WAIT);
   localparam logic [CNT_W-1:0] COUNT_MAX = '1;

   state_t           state;
   logic [3:0]       wait_cnt;
   logic [CNT_W-1:0] count;
   logic             ld_use;
   logic             pc_write;
   logic             ifid_write;
   logic             idex_bubble;
   logic             ifid_flush;

   always_comb begin
      ld_use = bus.idex_m_ctl[MEMREAD_BIT] && (bus.idex_rt != 5'd0) &&
               ((bus.idex_rt == bus.ifid_rs) ||
                (bus.ifid_uses_rt && (bus.idex_rt == bus.ifid_rt)));
   end

   // Mealy outputs; reset forces them even between clock edges.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      if (rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         ifid_flush  = 1'b1;
      end else if (bus.exmem_branch_taken) begin
         idex_bubble = 1'b1;
         ifid_flush  = 1'b1;
      end else if (state == MEMWAIT || ld_use) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= 4'd0;
         count    <= '0;
      end else begin
         if (!pc_write && count != COUNT_MAX) count <= count + 1'b1;
         if (bus.exmem_branch_taken) begin
            state    <= RUN;
            wait_cnt <= 4'd0;
         end else if (state == MEMWAIT) begin
            if (wait_cnt == 4'd1) begin
               state    <= RUN;
               wait_cnt <= 4'd0;
            end else begin
               wait_cnt <= wait_cnt - 4'd1;
            end
         end else if (ld_use && WAIT_INIT != 4'd0) begin
            // The first stall cycle happens in RUN; MEMWAIT covers the remaining N cycles.
            state    <= MEMWAIT;
            wait_cnt <= WAIT_INIT;
         end
      end
   end

   assign bus.pc_write     = pc_write;
   assign bus.ifid_write   = ifid_write;
   assign bus.idex_bubble  = idex_bubble;
   assign bus.ifid_flush   = ifid_flush;
   assign bus.hazard_state = state;
   assign bus.stall_count  = count;
endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl: three instances (MEM_WAIT 0/2/3) share one stimulus set
// and are checked against hand-computed values.
module tb_hazard_ctl;
   logic       clk;
   logic       rst;
   logic [4:0] ifid_rs;
   logic [4:0] ifid_rt;
   logic       ifid_uses_rt;
   logic [2:0] idex_m_ctl;
   logic [4:0] idex_rt;
   logic       branch;
   int         checks;
   int         failures;

   hazard_ctl_if #(.CNT_W(4))  bus0 ();
   hazard_ctl_if #(.CNT_W(16)) bus2 ();
   hazard_ctl_if #(.CNT_W(16)) bus3 ();

   assign bus0.ifid_rs = ifid_rs;  assign bus0.ifid_rt = ifid_rt;
   assign bus0.ifid_uses_rt = ifid_uses_rt;  assign bus0.idex_m_ctl = idex_m_ctl;
   assign bus0.idex_rt = idex_rt;  assign bus0.exmem_branch_taken = branch;
   assign bus2.ifid_rs = ifid_rs;  assign bus2.ifid_rt = ifid_rt;
   assign bus2.ifid_uses_rt = ifid_uses_rt;  assign bus2.idex_m_ctl = idex_m_ctl;
   assign bus2.idex_rt = idex_rt;  assign bus2.exmem_branch_taken = branch;
   assign bus3.ifid_rs = ifid_rs;  assign bus3.ifid_rt = ifid_rt;
   assign bus3.ifid_uses_rt = ifid_uses_rt;  assign bus3.idex_m_ctl = idex_m_ctl;
   assign bus3.idex_rt = idex_rt;  assign bus3.exmem_branch_taken = branch;

   hazard_ctl #(.MEMREAD_BIT(1), .MEM_WAIT(0), .CNT_W(4))  u0 (.clk(clk), .rst(rst), .bus(bus0));
   hazard_ctl #(.MEMREAD_BIT(1), .MEM_WAIT(2), .CNT_W(16)) u2 (.clk(clk), .rst(rst), .bus(bus2));
   hazard_ctl #(.MEMREAD_BIT(1), .MEM_WAIT(3), .CNT_W(16)) u3 (.clk(clk), .rst(rst), .bus(bus3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
      idex_m_ctl = 3'b000; idex_rt = 5'd0; branch = 1'b0;
   endtask

   task automatic load_use_rs8();
      idex_m_ctl = 3'b010; idex_rt = 5'd8; ifid_rs = 5'd8;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      idle();
      #2;
      // Reset values.
      check("rst_pc_write", 32'(bus0.pc_write), 32'd0);
      check("rst_ifid_write", 32'(bus0.ifid_write), 32'd0);
      check("rst_bubble", 32'(bus0.idex_bubble), 32'd1);
      check("rst_flush", 32'(bus0.ifid_flush), 32'd1);
      check("rst_state", 32'(bus0.hazard_state), 32'd0);
      check("rst_count", 32'(bus0.stall_count), 32'd0);

      // Test 1: MEM_WAIT=0, single-cycle load-use stall.
      do_reset();
      check("t1_idle_pc_write", 32'(bus0.pc_write), 32'd1);
      check("t1_idle_bubble", 32'(bus0.idex_bubble), 32'd0);
      load_use_rs8();
      #1;
      check("t1_stall_pc_write", 32'(bus0.pc_write), 32'd0);
      check("t1_stall_ifid_write", 32'(bus0.ifid_write), 32'd0);
      check("t1_stall_bubble", 32'(bus0.idex_bubble), 32'd1);
      check("t1_stall_flush", 32'(bus0.ifid_flush), 32'd0);
      tick();
      idle();
      #1;
      check("t1_after_pc_write", 32'(bus0.pc_write), 32'd1);
      check("t1_after_bubble", 32'(bus0.idex_bubble), 32'd0);
      check("t1_after_state", 32'(bus0.hazard_state), 32'd0);
      check("t1_count", 32'(bus0.stall_count), 32'd1);

      // Test 2: compares that must not stall, and one that must.
      do_reset();
      idex_m_ctl = 3'b010; idex_rt = 5'd8; ifid_rt = 5'd8; ifid_uses_rt = 1'b0; ifid_rs = 5'd3;
      #1;
      check("t2_rt_unused", 32'(bus0.pc_write), 32'd1);
      ifid_uses_rt = 1'b1;
      #1;
      check("t2_rt_used", 32'(bus0.pc_write), 32'd0);
      idex_m_ctl = 3'b101;
      #1;
      check("t2_no_memread", 32'(bus0.pc_write), 32'd1);
      idex_m_ctl = 3'b010; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
      #1;
      check("t2_r0", 32'(bus0.pc_write), 32'd1);

      // Test 3: MEM_WAIT=2, which gives three stall cycles.
      do_reset();
      load_use_rs8();
      #1;
      check("t3_c0_pc_write", 32'(bus2.pc_write), 32'd0);
      check("t3_c0_state", 32'(bus2.hazard_state), 32'd0);
      tick();
      idle();
      #1;
      check("t3_c1_pc_write", 32'(bus2.pc_write), 32'd0);
      check("t3_c1_state", 32'(bus2.hazard_state), 32'd1);
      tick();
      #1;
      check("t3_c2_pc_write", 32'(bus2.pc_write), 32'd0);
      check("t3_c2_bubble", 32'(bus2.idex_bubble), 32'd1);
      check("t3_c2_state", 32'(bus2.hazard_state), 32'd1);
      tick();
      #1;
      check("t3_c3_pc_write", 32'(bus2.pc_write), 32'd1);
      check("t3_c3_state", 32'(bus2.hazard_state), 32'd0);
      check("t3_count", 32'(bus2.stall_count), 32'd3);

      // Test 4: MEM_WAIT=3, with a branch on the second MEMWAIT cycle.
      do_reset();
      load_use_rs8();
      tick();
      idle();
      #1;
      check("t4_mw1_pc_write", 32'(bus3.pc_write), 32'd0);
      tick();
      branch = 1'b1;
      #1;
      check("t4_br_state", 32'(bus3.hazard_state), 32'd1);
      check("t4_br_pc_write", 32'(bus3.pc_write), 32'd1);
      check("t4_br_ifid_write", 32'(bus3.ifid_write), 32'd1);
      check("t4_br_flush", 32'(bus3.ifid_flush), 32'd1);
      check("t4_br_bubble", 32'(bus3.idex_bubble), 32'd1);
      tick();
      branch = 1'b0;
      #1;
      check("t4_after_state", 32'(bus3.hazard_state), 32'd0);
      check("t4_after_pc_write", 32'(bus3.pc_write), 32'd1);
      check("t4_count", 32'(bus3.stall_count), 32'd2);

      // Test 5: asynchronous reset in the middle of MEMWAIT.
      do_reset();
      load_use_rs8();
      tick();
      idle();
      #1;
      check("t5_pre_state", 32'(bus3.hazard_state), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_pc_write", 32'(bus3.pc_write), 32'd0);
      check("t5_rst_flush", 32'(bus3.ifid_flush), 32'd1);
      check("t5_rst_bubble", 32'(bus3.idex_bubble), 32'd1);
      check("t5_rst_state", 32'(bus3.hazard_state), 32'd0);
      check("t5_rst_count", 32'(bus3.stall_count), 32'd0);
      #2 rst = 1'b0;
      #1;
      check("t5_rel_pc_write", 32'(bus3.pc_write), 32'd1);
      tick();
      check("t5_rel_state", 32'(bus3.hazard_state), 32'd0);
      check("t5_rel_count", 32'(bus3.stall_count), 32'd0);

      // Test 6: the CNT_W=4 counter saturates at 15.
      do_reset();
      load_use_rs8();
      repeat (14) tick();
      check("t6_count14", 32'(bus0.stall_count), 32'd14);
      tick();
      check("t6_count15", 32'(bus0.stall_count), 32'd15);
      repeat (5) tick();
      check("t6_count_sat", 32'(bus0.stall_count), 32'd15);
      check("t6_state", 32'(bus0.hazard_state), 32'd0);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
